// File: rtl/z80_rf_pkg.sv
// Shared constants and types for the banked Z80 register file.
// Optional write bypass is enabled by defining Z80_RF_WRITE_BYPASS_EN.
package z80_rf_pkg;

  localparam int REG_A = 0;
  localparam int REG_F = 1;
  localparam int REG_B = 2;
  localparam int REG_C = 3;
  localparam int REG_D = 4;
  localparam int REG_E = 5;
  localparam int REG_H = 6;
  localparam int REG_L = 7;

  typedef enum logic [1:0] {
    PAIR_BC = 2'd0,
    PAIR_DE = 2'd1,
    PAIR_HL = 2'd2,
    PAIR_SP = 2'd3
  } pair_e;

  typedef enum logic {
    ADDR_PC = 1'b0,
    ADDR_SP = 1'b1
  } addr_sel_e;

  // A and F follow the EX AF,AF' bank; every other register follows EXX.
  function automatic logic is_af_reg(input int idx);
    return idx < 2;
  endfunction

endpackage

// File: rtl/z80_regfile_banked_if.sv
// Sequencer/ALU-side bundle of the banked register file.
// Master drives controls and write data; slave is the register file itself.
interface z80_regfile_banked_if #(
  parameter int DW   = 8,
  parameter int NREG = 8,
  parameter int NRD  = 2,
  parameter int AW   = 16
) ();
  localparam int SW = $clog2(NREG);

  logic              wr_en;
  logic [SW-1:0]     wr_sel;
  logic [DW-1:0]     wr_data;
  logic              alu_wr_en;
  logic [SW-1:0]     alu_wr_sel;
  logic [DW-1:0]     alu_wr_data;
  logic              flag_we;
  logic [DW-1:0]     flag_in;
  logic [NRD*SW-1:0] rd_sel;
  logic [NRD*DW-1:0] rd_data;
  logic              ex_af;
  logic              exx;
  logic              pc_inc;
  logic              pc_load;
  logic [AW-1:0]     pc_load_val;
  logic              sp_inc;
  logic              sp_dec;
  logic              sp_load;
  logic              addr_sel;
  logic [AW-1:0]     addr_bus;
  logic [AW-1:0]     pc_out;
  logic [AW-1:0]     sp_out;
  logic              bank_af;
  logic              bank_gp;

  modport master (
    output wr_en, wr_sel, wr_data, alu_wr_en, alu_wr_sel, alu_wr_data,
           flag_we, flag_in, rd_sel, ex_af, exx, pc_inc, pc_load,
           pc_load_val, sp_inc, sp_dec, sp_load, addr_sel,
    input  rd_data, addr_bus, pc_out, sp_out, bank_af, bank_gp
  );

  modport slave (
    input  wr_en, wr_sel, wr_data, alu_wr_en, alu_wr_sel, alu_wr_data,
           flag_we, flag_in, rd_sel, ex_af, exx, pc_inc, pc_load,
           pc_load_val, sp_inc, sp_dec, sp_load, addr_sel,
    output rd_data, addr_bus, pc_out, sp_out, bank_af, bank_gp
  );

endinterface

// File: rtl/z80_rf_bank.sv
// One DW x NREG register bank with a pre-resolved per-register write port
// and NRD combinational read ports; selects >= NREG read as zero.
module z80_rf_bank
  import z80_rf_pkg::*;
#(
  parameter int DW   = 8,
  parameter int NREG = 8,
  parameter int NRD  = 2,
  parameter int SW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREG-1:0]   we,
  input  logic [DW-1:0]     wdata [NREG],
  input  logic [NRD*SW-1:0] rd_sel,
  output logic [NRD*DW-1:0] rd_data,
  output logic [2*DW-1:0]   hl
);

  logic [DW-1:0] mem [NREG];

  // NOTE: the storage is flops, not RAM, so it is cleared by the async reset;
  // non-blocking assignments keep every element updating from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (we[i]) mem[i] <= wdata[i];
      end
    end
  end

  // NOTE: default the whole output first so no path through the loop infers a latch.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NRD; k++) begin
      if (int'(rd_sel[k*SW +: SW]) < NREG)
        rd_data[k*DW +: DW] = mem[rd_sel[k*SW +: SW]];
    end
  end

  assign hl = {mem[REG_H], mem[REG_L]};

endmodule

// File: rtl/z80_regfile_banked.sv
// Banked Z80 register file with PC/SP counters and address-bus mux.
// Define Z80_RF_WRITE_BYPASS_EN to forward same-cycle write data to read ports.
module z80_regfile_banked
  import z80_rf_pkg::*;
#(
  parameter int            DW       = 8,
  parameter int            NREG     = 8,
  parameter int            NRD      = 2,
  parameter int            AW       = 16,
  parameter logic [AW-1:0] PC_RESET = '0,
  localparam int           SW       = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 reset,
  z80_regfile_banked_if.slave  rf
);

  logic              bank_af;
  logic              bank_gp;
  logic [AW-1:0]     pc;
  logic [AW-1:0]     sp;
  logic [NREG-1:0]   res_we;
  logic [DW-1:0]     res_data [NREG];
  logic [NREG-1:0]   reg_alt;
  logic [NRD*DW-1:0] rd0;
  logic [NRD*DW-1:0] rd1;
  logic [2*DW-1:0]   hl0;
  logic [2*DW-1:0]   hl1;
  logic [2*DW-1:0]   hl_act;
  logic [DW-1:0]     rd_word [NRD];

  // Priority per register: flag write > ALU write > bus write.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      res_we[i]   = 1'b0;
      res_data[i] = '0;
      if (rf.wr_en && int'(rf.wr_sel) == i) begin
        res_we[i]   = 1'b1;
        res_data[i] = rf.wr_data;
      end
      if (rf.alu_wr_en && int'(rf.alu_wr_sel) == i) begin
        res_we[i]   = 1'b1;
        res_data[i] = rf.alu_wr_data;
      end
      if (i == REG_F && rf.flag_we) begin
        res_we[i]   = 1'b1;
        res_data[i] = rf.flag_in;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) reg_alt[i] = is_af_reg(i) ? bank_af : bank_gp;
  end

  // Writes go to whichever bank is active before the edge, even during a swap.
  z80_rf_bank #(.DW(DW), .NREG(NREG), .NRD(NRD), .SW(SW)) u_bank0 (
    .clk     (clk),
    .reset   (reset),
    .we      (res_we & ~reg_alt),
    .wdata   (res_data),
    .rd_sel  (rf.rd_sel),
    .rd_data (rd0),
    .hl      (hl0)
  );

  z80_rf_bank #(.DW(DW), .NREG(NREG), .NRD(NRD), .SW(SW)) u_bank1 (
    .clk     (clk),
    .reset   (reset),
    .we      (res_we & reg_alt),
    .wdata   (res_data),
    .rd_sel  (rf.rd_sel),
    .rd_data (rd1),
    .hl      (hl1)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [SW-1:0] sel;
    logic          use_alt;
    assign sel     = rf.rd_sel[k*SW +: SW];
    assign use_alt = is_af_reg(int'(sel)) ? bank_af : bank_gp;
`ifdef Z80_RF_WRITE_BYPASS_EN
    logic hit;
    assign hit        = (int'(sel) < NREG) && res_we[sel];
    assign rd_word[k] = hit     ? res_data[sel]
                      : use_alt ? rd1[k*DW +: DW] : rd0[k*DW +: DW];
`else
    assign rd_word[k] = use_alt ? rd1[k*DW +: DW] : rd0[k*DW +: DW];
`endif
  end

  always_comb begin
    rf.rd_data = '0;
    for (int k = 0; k < NRD; k++) rf.rd_data[k*DW +: DW] = rd_word[k];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_af <= 1'b0;
      bank_gp <= 1'b0;
    end else begin
      if (rf.ex_af) bank_af <= ~bank_af;
      if (rf.exx)   bank_gp <= ~bank_gp;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          pc <= PC_RESET;
    else if (rf.pc_load) pc <= rf.pc_load_val;
    else if (rf.pc_inc)  pc <= pc + AW'(1);
  end

  // SP loads from the pre-edge HL pair of the active general bank.
  assign hl_act = bank_gp ? hl1 : hl0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        sp <= '1;
    else if (rf.sp_load)               sp <= AW'(hl_act);
    else if (rf.sp_inc && !rf.sp_dec)  sp <= sp + AW'(1);
    else if (rf.sp_dec && !rf.sp_inc)  sp <= sp - AW'(1);
  end

  assign rf.addr_bus = (addr_sel_e'(rf.addr_sel) == ADDR_SP) ? sp : pc;
  assign rf.pc_out   = pc;
  assign rf.sp_out   = sp;
  assign rf.bank_af  = bank_af;
  assign rf.bank_gp  = bank_gp;

endmodule

// File: tb/tb_z80_regfile_banked.sv
// Directed scoreboard bench for z80_regfile_banked (default parameters).
// Expectations follow Z80_RF_WRITE_BYPASS_EN when it is defined.
module tb_z80_regfile_banked;
  import z80_rf_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;

  z80_regfile_banked_if rf ();

  z80_regfile_banked dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic expect_val(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [15:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rf.wr_en       = 1'b0;
    rf.wr_sel      = '0;
    rf.wr_data     = '0;
    rf.alu_wr_en   = 1'b0;
    rf.alu_wr_sel  = '0;
    rf.alu_wr_data = '0;
    rf.flag_we     = 1'b0;
    rf.flag_in     = '0;
    rf.ex_af       = 1'b0;
    rf.exx         = 1'b0;
    rf.pc_inc      = 1'b0;
    rf.pc_load     = 1'b0;
    rf.pc_load_val = '0;
    rf.sp_inc      = 1'b0;
    rf.sp_dec      = 1'b0;
    rf.sp_load     = 1'b0;
    rf.addr_sel    = 1'b0;
  endtask

  task automatic rd_port(input int port, input int sel, output logic [7:0] v);
    rf.rd_sel[port*3 +: 3] = 3'(sel);
    #1;
    v = rf.rd_data[port*8 +: 8];
  endtask

  task automatic chk_reg(input int sel);
    logic [7:0] v;
    rd_port(0, sel, v);
    check(16'(v));
  endtask

  task automatic bus_wr(input int sel, input logic [7:0] d);
    rf.wr_en   = 1'b1;
    rf.wr_sel  = 3'(sel);
    rf.wr_data = d;
  endtask

  initial begin
    logic [7:0] v;
    idle();
    rf.rd_sel = '0;
    #12 reset = 1'b1;
    tick();

    // Some activity, then an asynchronous reset in the middle of a cycle.
    bus_wr(REG_B, 8'h5A);
    tick(); idle();
    bus_wr(REG_C, 8'h12); rf.exx = 1'b1; rf.pc_inc = 1'b1; rf.ex_af = 1'b1;
    tick(); idle();
    bus_wr(REG_B, 8'hEE); rf.exx = 1'b1; rf.sp_dec = 1'b1;
    #3 reset = 1'b0;
    #2 idle();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      expect_val($sformatf("rst_reg%0d", i), 16'h0000);
      chk_reg(i);
    end
    expect_val("rst_pc", 16'h0000);   check(rf.pc_out);
    expect_val("rst_sp", 16'hFFFF);   check(rf.sp_out);
    expect_val("rst_addr", 16'h0000); check(rf.addr_bus);
    expect_val("rst_bank_af", 16'h0); check(16'(rf.bank_af));
    expect_val("rst_bank_gp", 16'h0); check(16'(rf.bank_gp));
    tick();

    // Write priority: ALU beats bus, flag beats ALU; disjoint targets both land.
    expect_val("prio_B", 16'h0022);
    bus_wr(REG_B, 8'h11);
    rf.alu_wr_en = 1'b1; rf.alu_wr_sel = 3'(REG_B); rf.alu_wr_data = 8'h22;
    tick(); idle();
    chk_reg(REG_B);
    expect_val("prio_F", 16'h0044);
    bus_wr(REG_F, 8'h55);
    rf.alu_wr_en = 1'b1; rf.alu_wr_sel = 3'(REG_F); rf.alu_wr_data = 8'h33;
    rf.flag_we = 1'b1; rf.flag_in = 8'h44;
    tick(); idle();
    chk_reg(REG_F);
    expect_val("dual_C", 16'h003C);
    expect_val("dual_D", 16'h004D);
    bus_wr(REG_C, 8'h3C);
    rf.alu_wr_en = 1'b1; rf.alu_wr_sel = 3'(REG_D); rf.alu_wr_data = 8'h4D;
    tick(); idle();
    chk_reg(REG_C);
    chk_reg(REG_D);

    // EXX swaps B; EX AF,AF' leaves B alone.
    bus_wr(REG_B, 8'h5A);
    tick(); idle();
    expect_val("exx_gp", 16'h1);
    expect_val("exx_B_alt", 16'h0000);
    rf.exx = 1'b1;
    tick(); idle();
    check(16'(rf.bank_gp));
    chk_reg(REG_B);
    bus_wr(REG_B, 8'hA5);
    tick(); idle();
    expect_val("exx_B_back", 16'h005A);
    rf.exx = 1'b1;
    tick(); idle();
    chk_reg(REG_B);
    bus_wr(REG_A, 8'h3A);
    tick(); idle();
    expect_val("exaf_bank", 16'h1);
    expect_val("exaf_A_alt", 16'h0000);
    expect_val("exaf_B_same", 16'h005A);
    rf.ex_af = 1'b1;
    tick(); idle();
    check(16'(rf.bank_af));
    chk_reg(REG_A);
    chk_reg(REG_B);
    expect_val("exaf_A_back", 16'h003A);
    rf.ex_af = 1'b1;
    tick(); idle();
    chk_reg(REG_A);

    // A write during EXX lands in the pre-swap bank.
    expect_val("swapwr_C_new", 16'h0000);
    expect_val("swapwr_C_old", 16'h0077);
    bus_wr(REG_C, 8'h77); rf.exx = 1'b1;
    tick(); idle();
    chk_reg(REG_C);
    rf.exx = 1'b1;
    tick(); idle();
    chk_reg(REG_C);

    // PC load, wrap on increment, load beats increment.
    expect_val("pc_load", 16'hFFFF);
    expect_val("pc_addr", 16'hFFFF);
    rf.pc_load = 1'b1; rf.pc_load_val = 16'hFFFF;
    tick(); idle();
    check(rf.pc_out);
    check(rf.addr_bus);
    expect_val("pc_wrap", 16'h0000);
    rf.pc_inc = 1'b1;
    tick(); idle();
    check(rf.pc_out);
    expect_val("pc_load_prio", 16'h1234);
    rf.pc_load = 1'b1; rf.pc_inc = 1'b1; rf.pc_load_val = 16'h1234;
    tick(); idle();
    check(rf.pc_out);

    // SP load from HL, dec, inc+dec hold, address mux, wrap both ways.
    bus_wr(REG_H, 8'h80);
    rf.alu_wr_en = 1'b1; rf.alu_wr_sel = 3'(REG_L); rf.alu_wr_data = 8'h00;
    tick(); idle();
    expect_val("sp_load", 16'h8000);
    rf.sp_load = 1'b1; rf.sp_dec = 1'b1;
    tick(); idle();
    check(rf.sp_out);
    expect_val("sp_dec", 16'h7FFF);
    rf.sp_dec = 1'b1;
    tick(); idle();
    check(rf.sp_out);
    expect_val("sp_hold", 16'h7FFF);
    expect_val("addr_sp", 16'h7FFF);
    rf.sp_inc = 1'b1; rf.sp_dec = 1'b1;
    tick(); idle();
    check(rf.sp_out);
    rf.addr_sel = 1'b1;
    #1 check(rf.addr_bus);
    rf.addr_sel = 1'b0;
    bus_wr(REG_H, 8'h00);
    tick(); idle();
    rf.sp_load = 1'b1;
    tick(); idle();
    expect_val("sp_wrap_dn", 16'hFFFF);
    rf.sp_dec = 1'b1;
    tick(); idle();
    check(rf.sp_out);
    expect_val("sp_wrap_up", 16'h0000);
    rf.sp_inc = 1'b1;
    tick(); idle();
    check(rf.sp_out);

    // Same-cycle read of a register being written.
`ifdef Z80_RF_WRITE_BYPASS_EN
    expect_val("byp_same", 16'h009C);
`else
    expect_val("byp_same", 16'h004D);
`endif
    expect_val("byp_next", 16'h009C);
    bus_wr(REG_D, 8'h9C);
    rd_port(1, REG_D, v);
    check(16'(v));
    tick(); idle();
    rd_port(1, REG_D, v);
    check(16'(v));

    if (sb.size() != 0) begin
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
